// File: rtl/laser_drop_pkg.sv
// Shared definitions for the laser drop byte queues (packing and unpacking).
// Holds the default queue depth and the byte/word data types so that both
// directions agree on widths.
package laser_drop_pkg;

   localparam int LD_QUEUE_DEPTH = 64;

   typedef logic [7:0]  ld_byte_t;
   typedef logic [15:0] ld_word_t;

endpackage

// File: rtl/laser_drop_pack_ptr.sv
// One wrapping pointer for the packing queue.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset, pointer to 0
//   clear  - synchronous flush, pointer to 0 (wins over step)
//   step   - advance the pointer this edge
//   amount - advance distance (1 for the write side, 2 for the read side)
//   ptr    - current pointer, wraps modulo 2**AW
module laser_drop_pack_ptr #(
   parameter int AW = 6
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          step,
   input  logic [1:0]    amount,
   output logic [AW-1:0] ptr
);

   // Natural binary overflow gives the modulo-DEPTH wrap for free.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (clear) begin
         ptr <= '0;
      end else if (step) begin
         ptr <= ptr + AW'(amount);
      end
   end

endmodule

// File: rtl/laser_drop_pack_queue.sv
// Byte-in / word-out queue: bytes arrive one at a time and leave in pairs as
// 16-bit words, oldest byte in the low half.
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-high reset
//   clear             - synchronous flush of pointers, size and sticky flags
//   D, load           - byte to enqueue and its request strobe
//   read              - dequeue one word (two bytes) at the next edge
//   Q                 - head word, combinational, valid while word_avail
//   size              - bytes held, 0..DEPTH
//   empty/full        - size == 0 / size == DEPTH
//   word_avail        - at least two bytes held
//   overflow          - sticky, a load was dropped because the queue was full
//   underflow         - sticky, a read was dropped for lack of a whole word
module laser_drop_pack_queue
   import laser_drop_pkg::*;
#(
   parameter int DEPTH = LD_QUEUE_DEPTH
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       clear,
   input  ld_byte_t                   D,
   input  logic                       load,
   input  logic                       read,
   output ld_word_t                   Q,
   output logic [$clog2(DEPTH):0]     size,
   output logic                       empty,
   output logic                       full,
   output logic                       word_avail,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = AW + 1;

   ld_byte_t      mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW-1:0] rp_hi;
   logic          acc_load;
   logic          acc_read;

   // Flags are derived from the registered size, so a byte written this
   // cycle cannot make a word visible until the following cycle.
   assign empty      = (size == '0);
   assign full       = (size == SW'(DEPTH));
   assign word_avail = (size >= SW'(2));

   // clear overrides both requests; a full queue drops the load even if a
   // read frees space on the same edge.
   assign acc_load = load && !full && !clear;
   assign acc_read = read && word_avail && !clear;

   laser_drop_pack_ptr #(.AW(AW)) u_wp (
      .clock  (clock),
      .reset  (reset),
      .clear  (clear),
      .step   (acc_load),
      .amount (2'd1),
      .ptr    (wp)
   );

   laser_drop_pack_ptr #(.AW(AW)) u_rp (
      .clock  (clock),
      .reset  (reset),
      .clear  (clear),
      .step   (acc_read),
      .amount (2'd2),
      .ptr    (rp)
   );

   // Contents are never reset; pointers and size alone define validity.
   always_ff @(posedge clock) begin
      if (acc_load && !reset) begin
         mem[wp] <= D;
      end
   end

   assign rp_hi = rp + AW'(1);
   assign Q     = {mem[rp_hi], mem[rp]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         size      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear) begin
         size      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         size <= size + SW'(acc_load) - (acc_read ? SW'(2) : SW'(0));
         if (load && full) begin
            overflow <= 1'b1;
         end
         if (read && !word_avail) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_laser_drop_pack_queue.sv
// Directed bench for laser_drop_pack_queue: hand-computed expectations for
// ordering, full/overflow, underflow, simultaneous load/read, pointer wrap,
// asynchronous reset and clear.
module tb_laser_drop_pack_queue;
   import laser_drop_pkg::*;

   logic       clock;
   logic       reset;
   logic       clear;
   ld_byte_t   D;
   logic       load;
   logic       read;
   ld_word_t   Q;
   logic [6:0] size;
   logic       empty;
   logic       full;
   logic       word_avail;
   logic       overflow;
   logic       underflow;

   int checks   = 0;
   int failures = 0;

   laser_drop_pack_queue #(.DEPTH(64)) dut (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .D          (D),
      .load       (load),
      .read       (read),
      .Q          (Q),
      .size       (size),
      .empty      (empty),
      .full       (full),
      .word_avail (word_avail),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      load = 1'b1;
      D    = b;
      tick();
      load = 1'b0;
   endtask

   task automatic pop();
      read = 1'b1;
      tick();
      read = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clear = 1'b0;
      load  = 1'b0;
      read  = 1'b0;
      D     = '0;
      #1;
      check("rst_size", 32'(size), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_wavail", 32'(word_avail), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_unf", 32'(underflow), 0);
      tick();
      reset = 1'b0;
      tick();

      // Two bytes form one word, first byte low.
      push(8'hA1);
      check("one_byte_size", 32'(size), 1);
      check("one_byte_no_word", 32'(word_avail), 0);
      push(8'hB2);
      check("pair_wavail", 32'(word_avail), 1);
      check("pair_q", 32'(Q), 32'hB2A1);
      check("pair_size", 32'(size), 2);
      pop();
      check("pair_read_size", 32'(size), 0);
      check("pair_read_empty", 32'(empty), 1);

      // Fill to capacity, overflow, drain in order.
      for (int i = 0; i < 63; i++) push(8'(i));
      check("fill63_full", 32'(full), 0);
      push(8'h3F);
      check("fill_full", 32'(full), 1);
      check("fill_size", 32'(size), 64);
      push(8'hFF);
      check("ovf_flag", 32'(overflow), 1);
      check("ovf_size", 32'(size), 64);
      for (int i = 0; i < 32; i++) begin
         check($sformatf("drain_q%0d", i), 32'(Q), {16'h0, 8'(2*i+1), 8'(2*i)});
         pop();
      end
      check("drain_empty", 32'(empty), 1);
      check("ovf_sticky", 32'(overflow), 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_ovf", 32'(overflow), 0);

      // Simultaneous load and read with three bytes held.
      push(8'h01);
      push(8'h02);
      push(8'h03);
      check("sim_pre_q", 32'(Q), 32'h0201);
      load = 1'b1;
      D    = 8'h55;
      read = 1'b1;
      tick();
      load = 1'b0;
      read = 1'b0;
      check("sim_size", 32'(size), 2);
      check("sim_q", 32'(Q), 32'h5503);
      pop();

      // Lone byte: read is dropped, byte waits for its partner.
      push(8'h66);
      pop();
      check("unf_flag", 32'(underflow), 1);
      check("unf_size", 32'(size), 1);
      push(8'h77);
      check("unf_wavail", 32'(word_avail), 1);
      check("unf_q", 32'(Q), 32'h7766);
      pop();

      // Wrap: bring both pointers to 62, then straddle the boundary.
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_unf", 32'(underflow), 0);
      for (int i = 0; i < 62; i++) push(8'hEE);
      for (int i = 0; i < 31; i++) pop();
      check("wrap_pre_empty", 32'(empty), 1);
      for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
      check("wrap_q0", 32'(Q), 32'h1110);
      pop();
      check("wrap_q1", 32'(Q), 32'h1312);
      pop();
      check("wrap_empty", 32'(empty), 1);
      push(8'hAB);
      push(8'hCD);
      check("wrap_after_q", 32'(Q), 32'hCDAB);
      pop();

      // Asynchronous reset with size=10 and overflow set.
      for (int i = 0; i < 64; i++) push(8'(i));
      push(8'hFF);
      for (int i = 0; i < 27; i++) pop();
      check("ar_pre_size", 32'(size), 10);
      check("ar_pre_ovf", 32'(overflow), 1);
      #2;
      reset = 1'b1;
      #1;
      check("ar_size", 32'(size), 0);
      check("ar_empty", 32'(empty), 1);
      check("ar_wavail", 32'(word_avail), 0);
      check("ar_ovf", 32'(overflow), 0);
      #1;
      reset = 1'b0;
      tick();
      push(8'h5A);
      push(8'hA5);
      check("ar_first_q", 32'(Q), 32'hA55A);

      // clear together with load: load ignored.
      clear = 1'b1;
      load  = 1'b1;
      D     = 8'h99;
      tick();
      clear = 1'b0;
      load  = 1'b0;
      check("clr_load_size", 32'(size), 0);
      check("clr_load_empty", 32'(empty), 1);
      push(8'h01);
      push(8'h02);
      check("clr_after_q", 32'(Q), 32'h0201);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/laser_drop_pack_queue.md
LASER_DROP_PACK_QUEUE -- requirements
Module: laser_drop_pack_queue

Interface
REQ-001 Parameter DEPTH, default 64: byte capacity; SHALL be an even power of two, at least 4.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clear  input  1  synchronous flush of all contents and flags.
REQ-005 D  input  8  received byte to enqueue.
REQ-006 load  input  1  enqueue request for D this cycle.
REQ-007 read  input  1  dequeue request for one 16-bit word (two bytes) this cycle.
REQ-008 Q  output  16  head word: low byte is the oldest byte, high byte is the next oldest.
REQ-009 size  output  $clog2(DEPTH)+1  bytes held, range 0..DEPTH inclusive.
REQ-010 empty  output  1  size == 0.
REQ-011 full  output  1  size == DEPTH.
REQ-012 word_avail  output  1  size >= 2.
REQ-013 overflow  output  1  sticky: a load was dropped.
REQ-014 underflow  output  1  sticky: a read was dropped.

Function
REQ-015 Storage SHALL be a DEPTH x 8 circular buffer with write pointer wp and read pointer rp, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-016 Accepted load (load && !full): mem[wp] <= D; wp <= wp+1.
REQ-017 Accepted read (read && word_avail): rp <= rp+2.
REQ-018 Q SHALL be combinational as {mem[rp+1], mem[rp]}, with the index wrapping modulo DEPTH; Q is don't-care while word_avail is 0.
REQ-019 Zero-latency read: when word_avail is 1, Q is valid in the same cycle, and read consumes that word at the next edge.
REQ-020 Byte order SHALL be the inverse of the host-side byte-unpacking queue: the first byte received lands in Q[7:0], the second in Q[15:8].
REQ-021 Per-cycle size update: size_next = size + accepted_load - 2*accepted_read; both terms are evaluated against pre-edge flags.
REQ-022 Simultaneous accepted load and read in one cycle SHALL both take effect (net size change -1).
REQ-023 A load while full SHALL be dropped, with no change to mem, wp or size, and SHALL set overflow; this holds even if a read is accepted in the same cycle.
REQ-024 A read while size < 2 SHALL be dropped and SHALL set underflow; a lone odd byte stays queued until its partner arrives.
REQ-025 A byte written in cycle N SHALL NOT count toward word_avail before cycle N+1 (no write-to-read bypass).
REQ-026 clear SHALL take priority over load and read: it zeroes wp, rp, size, overflow and underflow at the edge, and any same-cycle load/read is ignored.
REQ-027 Buffer contents SHALL NOT be reset or cleared; correctness relies only on the pointers and size.

Reset
REQ-028 Asserting reset SHALL immediately force wp=0, rp=0, size=0, overflow=0 and underflow=0, giving empty=1, full=0 and word_avail=0.
REQ-029 Reset asserted mid-operation SHALL discard all queued bytes; the first load after deassertion SHALL be stored at index 0.
REQ-030 Inputs SHALL be ignored on any edge where reset is high.

Structure
REQ-031 Package laser_drop_pkg SHALL hold LD_QUEUE_DEPTH (64) and the typedefs ld_byte_t (8 bits) and ld_word_t (16 bits), shared with the unpacking queue.
REQ-032 Sub-module laser_drop_pack_ptr SHALL implement one wrapping pointer (inputs: clock, reset, clear, step enable, step amount 1 or 2; output: pointer), instantiated once for wp and once for rp.
REQ-033 The top level SHALL contain only the storage array, the size/flag logic and the Q mux.

Verification
REQ-034 Reset, then load 0xA1 and 0xB2 on consecutive cycles -> word_avail=1, Q=0xB2A1, size=2; read -> size=0, empty=1.
REQ-035 Load 64 bytes 0x00..0x3F -> full=1, size=64; load 0xFF -> overflow=1, size stays 64; 32 reads return 0x0100, 0x0302, ... 0x3F3E.
REQ-036 With size=3, assert load (0x55) and read together -> size=2; Q then shows the next pair in order.
REQ-037 Hold size=1 and read -> underflow=1, size=1; load 0x77 -> word_avail=1, Q[15:8]=0x77.
REQ-038 Wrap: with rp=wp=62, load 4 bytes 0x10..0x13, then read twice -> Q=0x1110 then Q=0x1312, with pointers wrapping to index 2.
REQ-039 With size=10 and overflow=1, pulse reset asynchronously between edges -> outputs return to their reset values before the next edge; repeat the test with clear plus a simultaneous load -> size=0 after the edge.
